// File: rtl/term_pkg.sv
// Shared constants, state encoding and row/address helpers for the text terminal writer.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package term_pkg;

  localparam int AW = 11;

  localparam logic [6:0]    COLS       = 7'd80;
  localparam logic [4:0]    ROWS       = 5'd25;
  localparam logic [7:0]    BLANK      = 8'h20;
  localparam logic [7:0]    BLANK_CODE = BLANK + 8'd1;

  localparam logic [AW-1:0] ROW_LAST  = {4'd0, COLS} - 11'd1;
  localparam logic [AW-1:0] CELL_LAST = AW'(int'(COLS) * int'(ROWS) - 1);

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  // Logical row -> physical ring row; sum never exceeds 2*ROWS-2, so one subtract suffices.
  function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, row} + {1'b0, top};
    if (s >= {1'b0, ROWS}) s = s - {1'b0, ROWS};
    return s[4:0];
  endfunction

  // row*80 as shift-and-add.
  function automatic logic [AW-1:0] row_base(input logic [4:0] r);
    logic [AW-1:0] r_ext;
    r_ext = {6'd0, r};
    return (r_ext << 6) + (r_ext << 4);
  endfunction

endpackage

// File: rtl/term_writer.sv
// Byte stream -> 80x25 index-RAM writer with cursor tracking and ring-row scrolling.
// Latency: accepted byte's write and cursor/top_row update appear one cycle after acceptance.
// Backpressure: in_ready low while a full-screen or single-row clear is running.
module term_writer
  import term_pkg::*;
(
  input  logic          clk100,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [4:0]    top_row,
  output logic [AW-1:0] cursor_addr,
  output logic          busy
);

  state_t        state, state_d;
  logic [AW-1:0] clr_cnt, clr_cnt_d;
  logic [6:0]    col, col_d;
  logic [4:0]    row, row_d;
  logic [4:0]    top_d;
  logic [4:0]    old_top, old_top_d;
  logic          newline;

  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [7:0]    wr_data_d;
  logic [AW-1:0] cursor_d;
  logic          ready_d;

  logic          accept;
  logic          printable;

  assign accept    = in_valid && in_ready;
  assign printable = (in_data >= 8'h20) && (in_data != 8'h7F);

  // State register.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) state <= CLR_ALL;
    else        state <= state_d;
  end

  // Next state plus cursor / ring bookkeeping.
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    col_d     = col;
    row_d     = row;
    top_d     = top_row;
    old_top_d = old_top;
    newline   = 1'b0;
    case (state)
      CLR_ALL: begin
        clr_cnt_d = clr_cnt + 11'd1;
        if (clr_cnt == CELL_LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
          top_d     = '0;
        end
      end
      CLR_ROW: begin
        clr_cnt_d = clr_cnt + 11'd1;
        if (clr_cnt == ROW_LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        if (accept) begin
          if (printable) begin
            if (col == COLS - 7'd1) begin
              col_d   = '0;
              newline = 1'b1;
            end else begin
              col_d = col + 7'd1;
            end
          end else begin
            case (in_data)
              CR: col_d = '0;
              LF: begin
                col_d   = '0;
                newline = 1'b1;
              end
              BS: if (col != 7'd0) col_d = col - 7'd1;
              FF: begin
                // Address 0 is written in the accept cycle, so the counter resumes at 1.
                top_d     = '0;
                col_d     = '0;
                row_d     = '0;
                state_d   = CLR_ALL;
                clr_cnt_d = 11'd1;
              end
              default: ;
            endcase
          end
          if (newline) begin
            if (row != ROWS - 5'd1) begin
              row_d = row + 5'd1;
            end else begin
              old_top_d = top_row;
              top_d     = (top_row == ROWS - 5'd1) ? 5'd0 : top_row + 5'd1;
              state_d   = CLR_ROW;
              clr_cnt_d = '0;
            end
          end
        end
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    case (state)
      CLR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt;
        wr_data_d = BLANK_CODE;
      end
      CLR_ROW: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base(old_top) + clr_cnt;
        wr_data_d = BLANK_CODE;
      end
      default: begin
        if (accept && printable) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cursor_addr;
          wr_data_d = in_data + 8'd1;
        end else if (accept && in_data == FF) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = BLANK_CODE;
        end
      end
    endcase
    // Ready only once IDLE has been held for a cycle, so it rises after the last clear write.
    ready_d  = (state == IDLE) && (state_d == IDLE);
    cursor_d = row_base(phys_row(row_d, top_d)) + {4'd0, col_d};
  end

  // Datapath and output registers.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      top_row     <= '0;
      old_top     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cursor_addr <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      clr_cnt     <= clr_cnt_d;
      col         <= col_d;
      row         <= row_d;
      top_row     <= top_d;
      old_top     <= old_top_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      cursor_addr <= cursor_d;
      in_ready    <= ready_d;
      busy        <= !ready_d;
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: clears, printing, wrap, LF scroll, BS, FF and mid-clear reset.
// Latency: n/a.
// Backpressure: stimulus only drives bytes while in_ready is high.
module tb_term_writer;
  import term_pkg::*;

  logic          clk100 = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [4:0]    top_row;
  logic [AW-1:0] cursor_addr;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  term_writer dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .top_row     (top_row),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  // Present one byte for one edge; leaves us at edge+1 of the cycle after acceptance.
  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Packs {wr_en, in_ready, busy, wr_addr, wr_data} for compact per-cycle compares.
  function automatic logic [31:0] wr_word(input logic en, input logic rdy, input logic bsy,
                                          input logic [10:0] a, input logic [7:0] d);
    return {10'd0, en, rdy, bsy, a, d};
  endfunction

  // Full-screen clear: 2000 ascending blank writes with in_ready low, then ready with cursor home.
  task automatic clear_all_check(input bit first_visible);
    for (int i = 0; i < 2000; i++) begin
      if (!(first_visible && i == 0)) tick();
      chk("clr_all_write", wr_word(wr_en, in_ready, busy, wr_addr, wr_data),
          wr_word(1'b1, 1'b0, 1'b1, 11'(i), 8'h21));
    end
    tick();
    chk("clr_all_done_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_all_done_wr_en", {31'd0, wr_en}, 32'd0);
    chk("clr_all_done_cursor", {21'd0, cursor_addr}, 32'd0);
    chk("clr_all_done_top", {27'd0, top_row}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},  {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {21'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    chk({tag, "_top_row"}, {27'd0, top_row}, 32'd0);
    chk({tag, "_cursor"}, {21'd0, cursor_addr}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state.
    #12;
    check_reset_outputs("reset");
    @(negedge clk100);
    rst_n = 1'b1;

    // Power-on clear.
    clear_all_check(1'b0);

    // "AB" back to back.
    in_valid = 1'b1;
    in_data  = 8'h41;
    tick();
    chk("A_write", wr_word(wr_en, 1'b0, 1'b0, wr_addr, wr_data), wr_word(1'b1, 1'b0, 1'b0, 11'd0, 8'h42));
    in_data = 8'h42;
    tick();
    in_valid = 1'b0;
    chk("B_write", wr_word(wr_en, 1'b0, 1'b0, wr_addr, wr_data), wr_word(1'b1, 1'b0, 1'b0, 11'd1, 8'h43));
    chk("AB_cursor", {21'd0, cursor_addr}, 32'd2);

    // CR back to column 0, no write.
    put(CR);
    chk("CR_no_write", {31'd0, wr_en}, 32'd0);
    chk("CR_cursor", {21'd0, cursor_addr}, 32'd0);

    // 80 'x' on row 0, one per cycle, wrapping onto row 1 without stall.
    for (int i = 0; i < 80; i++) begin
      chk("x_ready", {31'd0, in_ready}, 32'd1);
      put(8'h78);
      chk("x_write", wr_word(wr_en, 1'b0, 1'b0, wr_addr, wr_data),
          wr_word(1'b1, 1'b0, 1'b0, 11'(i), 8'h79));
    end
    chk("x_wrap_cursor", {21'd0, cursor_addr}, 32'd80);
    chk("x_wrap_ready", {31'd0, in_ready}, 32'd1);

    // 23 LFs down to row 24, then 5 'y'.
    for (int i = 0; i < 23; i++) put(LF);
    chk("lf_row24_cursor", {21'd0, cursor_addr}, 32'd1920);
    for (int i = 0; i < 5; i++) put(8'h79);
    chk("y_last_addr", {21'd0, wr_addr}, 32'd1924);
    chk("y_cursor", {21'd0, cursor_addr}, 32'd1925);

    // LF on the bottom row scrolls: top_row 0->1, clears physical row 0.
    put(LF);
    chk("scroll_top", {27'd0, top_row}, 32'd1);
    chk("scroll_ready_low", {31'd0, in_ready}, 32'd0);
    chk("scroll_no_write", {31'd0, wr_en}, 32'd0);
    chk("scroll_cursor", {21'd0, cursor_addr}, 32'd0);
    for (int i = 0; i < 80; i++) begin
      tick();
      chk("clr_row_write", wr_word(wr_en, in_ready, busy, wr_addr, wr_data),
          wr_word(1'b1, 1'b0, 1'b1, 11'(i), 8'h21));
    end
    tick();
    chk("clr_row_done_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_row_done_cursor", {21'd0, cursor_addr}, 32'd0);

    // Q, BS, R overwrite the same cell; BS at column 0 does nothing.
    put(8'h51);
    chk("Q_write", wr_word(wr_en, 1'b0, 1'b0, wr_addr, wr_data), wr_word(1'b1, 1'b0, 1'b0, 11'd0, 8'h52));
    put(BS);
    chk("BS_no_write", {31'd0, wr_en}, 32'd0);
    chk("BS_cursor", {21'd0, cursor_addr}, 32'd0);
    put(8'h52);
    chk("R_write", wr_word(wr_en, 1'b0, 1'b0, wr_addr, wr_data), wr_word(1'b1, 1'b0, 1'b0, 11'd0, 8'h53));
    chk("R_cursor", {21'd0, cursor_addr}, 32'd1);
    put(BS);
    put(BS);
    chk("BS_col0_cursor", {21'd0, cursor_addr}, 32'd0);
    chk("BS_col0_no_write", {31'd0, wr_en}, 32'd0);

    // Ignored control byte and DEL.
    put(8'h01);
    chk("ctl_01_ignored", {10'd0, wr_en, 10'd0, cursor_addr}, 32'd0);
    put(8'h7F);
    chk("del_ignored", {10'd0, wr_en, 10'd0, cursor_addr}, 32'd0);

    // Wrap-then-scroll: 80 'z' on the bottom row; clear targets physical row 1.
    for (int i = 0; i < 80; i++) begin
      chk("z_ready", {31'd0, in_ready}, 32'd1);
      put(8'h7A);
      chk("z_write", wr_word(wr_en, 1'b0, 1'b0, wr_addr, wr_data),
          wr_word(1'b1, 1'b0, 1'b0, 11'(i), 8'h7B));
    end
    chk("wrap_scroll_top", {27'd0, top_row}, 32'd2);
    chk("wrap_scroll_ready_low", {31'd0, in_ready}, 32'd0);
    chk("wrap_scroll_cursor", {21'd0, cursor_addr}, 32'd80);
    for (int i = 0; i < 80; i++) begin
      tick();
      chk("wrap_clr_write", wr_word(wr_en, in_ready, busy, wr_addr, wr_data),
          wr_word(1'b1, 1'b0, 1'b1, 11'(80 + i), 8'h21));
    end
    tick();
    chk("wrap_clr_done_ready", {31'd0, in_ready}, 32'd1);

    // Form feed: top_row to 0 and an immediate full clear.
    put(FF);
    chk("ff_top", {27'd0, top_row}, 32'd0);
    chk("ff_cursor", {21'd0, cursor_addr}, 32'd0);
    clear_all_check(1'b1);

    // Scroll again from top 0, then reset in the middle of the row clear.
    for (int i = 0; i < 24; i++) put(LF);
    chk("lf24_cursor", {21'd0, cursor_addr}, 32'd1920);
    put(LF);
    chk("scroll2_top", {27'd0, top_row}, 32'd1);
    for (int i = 0; i <= 40; i++) begin
      tick();
      chk("pre_reset_clr", wr_word(wr_en, in_ready, busy, wr_addr, wr_data),
          wr_word(1'b1, 1'b0, 1'b1, 11'(i), 8'h21));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midclr_reset");
    @(negedge clk100);
    rst_n = 1'b1;
    clear_all_check(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
